product_accumulator: RTL and testbench

Sequential multiply-accumulate back end that sits directly downstream of the 16x16 array multiplier. It consumes the multiplier's 32-bit product through a valid/ready handshake and sums a programmed number of products into a wide saturating accumulator. It then presents the result on an output handshake. A dot-product engine is the multiplier plus this block.

---
 rtl/product_accumulator.sv | 70 +++++++
 tb/tb_product_accumulator.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/product_accumulator.sv
// product_accumulator: sums a programmed number of unsigned products into a saturating accumulator.
module product_accumulator #(
  parameter int PW = 32,
  parameter int AW = 40,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [CW-1:0] count,
  input  logic [PW-1:0] p_in,
  input  logic          p_valid,
  output logic          p_ready,
  output logic [AW-1:0] acc,
  output logic          acc_valid,
  input  logic          acc_ready,
  output logic          busy,
  output logic          ovf
);
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
  state_t state, state_n;
  logic [CW-1:0] rem, rem_n;
  logic [AW-1:0] acc_n;
  logic ovf_n;
  logic [AW:0] sum;
  always_comb begin
    state_n = state;
    acc_n = acc;
    ovf_n = ovf;
    rem_n = rem;
    sum = {1'b0, acc} + {{(AW - PW + 1){1'b0}}, p_in};
    unique case (state)
      IDLE: if (start) begin
        acc_n = '0;
        ovf_n = 1'b0;
        rem_n = count;
        state_n = (count != '0) ? ACCUM : DONE;
      end
      ACCUM: if (p_valid) begin
        // saturate on carry-out; an all-ones accumulator stays all-ones
        acc_n = sum[AW] ? '1 : sum[AW-1:0];
        ovf_n = ovf | sum[AW];
        rem_n = rem - 1'b1;
        state_n = (rem == CW'(1)) ? DONE : ACCUM;
      end
      DONE: state_n = acc_ready ? IDLE : DONE;
      default: state_n = IDLE;
    endcase
  end
  // status flags are decoded from next state so every output comes straight from a flop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      acc <= '0;
      ovf <= 1'b0;
      rem <= '0;
      p_ready <= 1'b0;
      acc_valid <= 1'b0;
      busy <= 1'b0;
    end else begin
      state <= state_n;
      acc <= acc_n;
      ovf <= ovf_n;
      rem <= rem_n;
      p_ready <= state_n == ACCUM;
      acc_valid <= state_n == DONE;
      busy <= state_n != IDLE;
    end
  end
endmodule

// File: tb/tb_product_accumulator.sv
// tb_product_accumulator: scoreboard bench for the saturating product accumulator (AW=34).
module tb_product_accumulator;
  localparam int PW = 32;
  localparam int AW = 34;
  localparam int CW = 8;
  localparam logic [AW:0] MAX = {1'b0, {AW{1'b1}}};
  logic clk = 0, rst_n = 0, start = 0, p_valid = 0, acc_ready = 0;
  logic [CW-1:0] count = '0;
  logic [PW-1:0] p_in = '0;
  logic p_ready, acc_valid, busy, ovf;
  logic [AW-1:0] acc;
  int tests = 0, fails = 0;
  typedef struct packed {logic [AW-1:0] acc; logic ovf;} res_t;
  res_t sb[$];
  logic [PW-1:0] prod[8];

  product_accumulator #(.PW(PW), .AW(AW), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .count(count), .p_in(p_in),
    .p_valid(p_valid), .p_ready(p_ready), .acc(acc), .acc_valid(acc_valid),
    .acc_ready(acc_ready), .busy(busy), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic run_job(input int n, input int stall, input int hold, input int mid_start);
    logic [AW:0] m;
    logic mo;
    res_t r;
    int w;
    m = '0;
    mo = 1'b0;
    @(negedge clk);
    start = 1;
    count = n[CW-1:0];
    @(negedge clk);
    start = 0;
    count = 8'hAA;
    check("clr_acc", acc, 0);
    check("clr_ovf", ovf, 0);
    if (n == 0) sb.push_back('{acc: '0, ovf: 1'b0});
    else check("start_ready", p_ready, 1);
    for (int i = 0; i < n; i++) begin
      for (int s = 0; s < stall; s++) begin
        p_valid = 0;
        p_in = $urandom;
        @(negedge clk);
        check("stall_acc", acc, m);
        check("stall_ready", p_ready, 1);
      end
      p_valid = 1;
      p_in = prod[i];
      start = (mid_start == i);
      count = 8'd1;
      m = m + {3'b0, prod[i]};
      if (m > MAX) begin
        m = MAX;
        mo = 1'b1;
      end
      if (i == n - 1) sb.push_back('{acc: m[AW-1:0], ovf: mo});
      @(negedge clk);
      start = 0;
      p_valid = 0;
      if (i < n - 1) check("partial_acc", acc, m);
    end
    check("valid_latency", acc_valid, 1);
    w = 0;
    while (!acc_valid && w < 20) begin
      @(negedge clk);
      w++;
    end
    r = sb.pop_front();
    check("acc", acc, r.acc);
    check("ovf", ovf, r.ovf);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_acc", acc, r.acc);
      check("hold_valid", acc_valid, 1);
    end
    acc_ready = 1;
    @(negedge clk);
    acc_ready = 0;
    check("idle_valid", acc_valid, 0);
    check("idle_busy", busy, 0);
    check("kept_acc", acc, r.acc);
  endtask

  initial begin
    p_valid = 1;
    p_in = 32'h1234;
    repeat (3) @(negedge clk);
    check("rst_outs", {p_ready, acc_valid, busy, ovf}, 0);
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("idle_ready", p_ready, 0);
      check("idle_acc", acc, 0);
      check("idle_outs", {acc_valid, busy, ovf}, 0);
    end
    p_valid = 0;

    prod[0] = 32'h00001900; prod[1] = 32'h033E9C60;
    run_job(2, 0, 0, -1);

    prod[0] = 1; prod[1] = 2; prod[2] = 3;
    run_job(3, 4, 5, -1);

    for (int i = 0; i < 5; i++) prod[i] = 32'hFFFFFFFF;
    run_job(5, 0, 1, -1);

    run_job(0, 0, 0, -1);

    prod[0] = 32'h10; prod[1] = 32'h20;
    run_job(2, 1, 0, 1);

    @(negedge clk);
    start = 1;
    count = 4;
    @(negedge clk);
    start = 0;
    for (int i = 0; i < 2; i++) begin
      p_valid = 1;
      p_in = 32'h55;
      @(negedge clk);
    end
    check("pre_rst_acc", acc, 32'hAA);
    rst_n = 0;
    #1;
    check("rst_acc", acc, 0);
    check("rst_outs2", {p_ready, acc_valid, busy, ovf}, 0);
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_valid", acc_valid, 0);
    end
    p_valid = 0;
    prod[0] = 7;
    run_job(1, 0, 0, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
